// File: rtl/gpr_bus_pkg.sv
// gpr_bus_pkg
//   Shared sizing constants and the FSM state type for the GPR bus master.
//   NREG : number of GPRs on the shared buses (x0 is hardwired zero)
//   XLEN : width of buses A/B/C and of the broadcast write data
//   IDXW : register index width, log2(NREG)
package gpr_bus_pkg;

  localparam int NREG = 32;
  localparam int XLEN = 32;
  localparam int IDXW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } gpr_state_e;

endpackage

// File: rtl/gpr_onehot_dec.sv
// gpr_onehot_dec
//   Index-to-one-hot decoder used for every enable vector on the GPR buses.
//   Ports:
//     en     in   1      when low the output is all zeros
//     idx    in   IDXW   register index to select
//     onehot out  NREG   bit idx set when en is high, otherwise zero
module gpr_onehot_dec #(
  parameter int NREG = 32,
  parameter int IDXW = 5
) (
  input  logic            en,
  input  logic [IDXW-1:0] idx,
  output logic [NREG-1:0] onehot
);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
    assign onehot[gi] = en && (idx == IDXW'(gi));
  end

endmodule

// File: rtl/gpr_bus_master.sv
// gpr_bus_master
//   Register-file side master of the shared tri-state GPR buses. Accepts an
//   operand-fetch request (rs1, rs2), drives one-hot read enables on buses
//   A and B for one cycle, captures the resolved bus values and presents
//   them over a valid/ready handshake. Writebacks are broadcast every cycle
//   they occur; a read that hits the in-flight write is served from bus C.
//   Ports:
//     clk, rst                        clock, async active-high reset
//     req_valid/req_ready/req_rs1/req_rs2   operand-fetch request
//     rsp_valid/rsp_ready/rsp_op_a/rsp_op_b operand response
//     wb_valid/wb_rd/wb_data          writeback (never stalled)
//     gpr_wt_data                     broadcast write data to all GPRs
//     rd_A_en/rd_B_en/wt_en/through_C_en   one-hot bus enables
//     bus_A/bus_B/bus_C               resolved bus values
module gpr_bus_master #(
  parameter int NREG = gpr_bus_pkg::NREG,
  parameter int XLEN = gpr_bus_pkg::XLEN,
  parameter int IDXW = gpr_bus_pkg::IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDXW-1:0] req_rs1,
  input  logic [IDXW-1:0] req_rs2,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_op_a,
  output logic [XLEN-1:0] rsp_op_b,
  input  logic            wb_valid,
  input  logic [IDXW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] gpr_wt_data,
  output logic [NREG-1:0] rd_A_en,
  output logic [NREG-1:0] rd_B_en,
  output logic [NREG-1:0] wt_en,
  output logic [NREG-1:0] through_C_en,
  input  logic [XLEN-1:0] bus_A,
  input  logic [XLEN-1:0] bus_B,
  input  logic [XLEN-1:0] bus_C
);

  import gpr_bus_pkg::*;

  gpr_state_e      state_reg, state_next;
  logic [IDXW-1:0] rs1_reg, rs2_reg;
  logic [XLEN-1:0] op_a_reg, op_b_reg;

  logic load_req;
  logic rd_phase;
  logic wb_hit;
  logic byp_a, byp_b;

  // Next-state and handshake logic.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    load_req   = 1'b0;
    rd_phase   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load_req   = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        rd_phase   = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        // A new request can only enter while the current response leaves.
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            load_req   = 1'b1;
            state_next = READ;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state_reg == HOLD);
  assign rsp_op_a  = op_a_reg;
  assign rsp_op_b  = op_b_reg;

  // x0 is never written, so it never needs the through path.
  assign wb_hit = wb_valid && (wb_rd != '0);
  assign byp_a  = rd_phase && wb_hit && (wb_rd == rs1_reg);
  assign byp_b  = rd_phase && wb_hit && (wb_rd == rs2_reg);

  assign gpr_wt_data = wb_data;

  // Every enable is gated by rst so nothing drives the buses during reset,
  // including the purely combinational writeback path.
  gpr_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_a (
    .en     (rd_phase && !byp_a && !rst),
    .idx    (rs1_reg),
    .onehot (rd_A_en)
  );

  gpr_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_b (
    .en     (rd_phase && !byp_b && !rst),
    .idx    (rs2_reg),
    .onehot (rd_B_en)
  );

  gpr_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_w (
    .en     (wb_valid && !rst),
    .idx    (wb_rd),
    .onehot (wt_en)
  );

  // Both operands may hit the same write; C carries it once for both.
  gpr_onehot_dec #(.NREG(NREG), .IDXW(IDXW)) u_dec_c (
    .en     ((byp_a || byp_b) && !rst),
    .idx    (wb_rd),
    .onehot (through_C_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_req) begin
        rs1_reg <= req_rs1;
        rs2_reg <= req_rs2;
      end
      if (rd_phase) begin
        op_a_reg <= byp_a ? bus_C : bus_A;
        op_b_reg <= byp_b ? bus_C : bus_B;
      end
    end
  end

endmodule
